// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch front end. Issues one read at a time to instruction
// memory, waits for the word to return, and presents it together with its
// address in a single registered output slot for the decode stage. A
// downstream redirect (branch_taken) overrides everything: the slot is
// flushed and any read still in flight is marked to be discarded on return.
//
// Parameters
//   PC_WIDTH    - program counter / instruction-memory address width
//   INSTR_WIDTH - instruction word width (at least 8)
//   RESET_PC    - PC loaded on reset (word aligned)
//
// Ports
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   imem_req      out  one-cycle read request pulse
//   imem_addr     out  read address, meaningful while imem_req=1
//   imem_rvalid   in   read data valid (one per request, >=1 cycle later)
//   imem_rdata    in   read data
//   stall         in   decode cannot accept; output slot holds
//   branch_taken  in   redirect pulse
//   branch_target in   redirect address (low 2 bits ignored)
//   if_valid      out  output slot holds a live instruction
//   if_instr      out  fetched instruction word
//   if_pc         out  address of if_instr
//   opcode        out  top 8 bits of if_instr (combinational)
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic                   if_valid,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [PC_WIDTH-1:0]    if_pc,
  output logic [7:0]             opcode
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic                   kill_q, kill_d;
  logic                   if_valid_q, if_valid_d;
  logic [INSTR_WIDTH-1:0] if_instr_q, if_instr_d;
  logic [PC_WIDTH-1:0]    if_pc_q, if_pc_d;
  logic [INSTR_WIDTH-1:0] hold_q, hold_d;

  logic [PC_WIDTH-1:0]    pc_inc;
  logic [PC_WIDTH-1:0]    redirect_pc;
  logic                   slot_free;
  logic                   resp_arrives;

  // Wraps naturally at 2^PC_WIDTH.
  assign pc_inc       = pc_q + PC_WIDTH'(4);
  assign redirect_pc  = branch_target & ~PC_WIDTH'(3);
  assign slot_free    = !if_valid_q || !stall;
  // Responses are only meaningful while a request is outstanding.
  assign resp_arrives = (state_q == S_WAIT) && imem_rvalid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid) begin
          // Dropped responses and loads into a free slot both refetch at once.
          if (branch_taken || kill_q || slot_free) state_d = S_FETCH;
          else                                      state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (branch_taken || !stall) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    imem_req  = (state_q == S_FETCH);
    imem_addr = pc_q;
  end

  // Datapath next-state
  always_comb begin
    pc_d       = pc_q;
    kill_d     = kill_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    hold_d     = hold_q;

    // A presented instruction is consumed when decode is not stalled;
    // a load below re-asserts valid in the same cycle.
    if (if_valid_q && !stall) if_valid_d = 1'b0;

    // The outstanding response is retired whenever it shows up.
    if (resp_arrives) kill_d = 1'b0;

    if (branch_taken) begin
      pc_d       = redirect_pc;
      if_valid_d = 1'b0;
      // A read already issued will still come back and must be discarded.
      if (state_q == S_FETCH || (state_q == S_WAIT && !imem_rvalid)) kill_d = 1'b1;
    end else begin
      if (resp_arrives && !kill_q) begin
        if (slot_free) begin
          if_instr_d = imem_rdata;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_inc;
        end else begin
          hold_d = imem_rdata;
        end
      end else if (state_q == S_HOLD && !stall) begin
        if_instr_d = hold_q;
        if_pc_d    = pc_q;
        if_valid_d = 1'b1;
        pc_d       = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      hold_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      hold_q     <= hold_d;
    end
  end

  assign if_valid = if_valid_q;
  assign if_instr = if_instr_q;
  assign if_pc    = if_pc_q;
  assign opcode   = if_instr_q[INSTR_WIDTH-1 -: 8];

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Scoreboard bench for fetch_stage. Stimulus pushes expected memory requests,
// expected delivered instructions and timed probes into queues; a single
// monitor on the falling clock edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam int P_VALID = 0;
  localparam int P_PC    = 1;
  localparam int P_INSTR = 2;
  localparam int P_OPC   = 3;
  localparam int P_REQ   = 4;
  localparam int P_ADDR  = 5;
  localparam int P_EMPTY = 6;

  typedef struct { int cyc; logic [31:0] addr; } req_t;
  typedef struct { int cyc; logic [31:0] pc; logic [31:0] instr; } out_t;
  typedef struct { int cyc; int kind; logic [31:0] exp; } probe_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [7:0]  opcode;

  logic        auto_mem;
  int          mem_lat;
  logic        auto_rv, man_rv;
  logic [31:0] auto_rd, man_rd;

  assign imem_rvalid = auto_mem ? auto_rv : man_rv;
  assign imem_rdata  = auto_mem ? auto_rd : man_rd;

  req_t   req_q[$];
  out_t   out_q[$];
  probe_t probe_q[$];

  int cyc_cnt = 0;
  int n_vec   = 0;
  int n_err   = 0;

  fetch_stage #(
    .PC_WIDTH   (32),
    .INSTR_WIDTH(32),
    .RESET_PC   (32'h0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .opcode       (opcode)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[7:0] ^ 8'hC3, 8'h00, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc_cnt, act, exp);
    end
  endtask

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge clk) begin : mon
    req_t   e;
    out_t   o;
    probe_t p;
    if (rst_n === 1'b1 && imem_req === 1'b1) begin
      if (req_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_req at cycle %0d: got addr 0x%08h, expected no request", cyc_cnt, imem_addr);
      end else begin
        e = req_q.pop_front();
        check("req_addr", imem_addr, e.addr);
        check("req_cycle", 32'(cyc_cnt), 32'(e.cyc));
      end
    end
    if (rst_n === 1'b1 && if_valid === 1'b1 && stall === 1'b0) begin
      if (out_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_out at cycle %0d: got pc 0x%08h instr 0x%08h, expected none", cyc_cnt, if_pc, if_instr);
      end else begin
        o = out_q.pop_front();
        check("out_pc", if_pc, o.pc);
        check("out_instr", if_instr, o.instr);
        check("out_opcode", {24'h0, opcode}, {24'h0, o.instr[31:24]});
        check("out_cycle", 32'(cyc_cnt), 32'(o.cyc));
      end
    end
    while (probe_q.size() > 0 && probe_q[0].cyc <= cyc_cnt) begin
      p = probe_q.pop_front();
      case (p.kind)
        P_VALID: check("if_valid", {31'h0, if_valid}, p.exp);
        P_PC:    check("if_pc", if_pc, p.exp);
        P_INSTR: check("if_instr", if_instr, p.exp);
        P_OPC:   check("opcode", {24'h0, opcode}, p.exp);
        P_REQ:   check("imem_req", {31'h0, imem_req}, p.exp);
        P_ADDR:  check("imem_addr", imem_addr, p.exp);
        default: check("sb_drained", 32'(req_q.size() + out_q.size()), p.exp);
      endcase
    end
  end

  // Auto-responding memory: answers each request mem_lat cycles later.
  initial begin : resp
    logic        pend;
    int          cnt;
    logic [31:0] paddr;
    pend = 1'b0; cnt = 0; paddr = '0;
    auto_rv = 1'b0; auto_rd = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && auto_mem && imem_req === 1'b1) begin
        pend = 1'b1; paddr = imem_addr; cnt = mem_lat;
      end
      @(posedge clk);
      #1;
      auto_rv = 1'b0;
      if (rst_n !== 1'b1 || !auto_mem) begin
        pend = 1'b0;
      end else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          auto_rv = 1'b1;
          auto_rd = mem_data(paddr);
          pend    = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  task automatic wait_cyc(input int x);
    while (cyc_cnt < x) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_req(input logic [31:0] a, input int c);
    req_t e;
    e.cyc = c; e.addr = a;
    req_q.push_back(e);
  endtask

  task automatic exp_out(input logic [31:0] pc, input logic [31:0] instr, input int c);
    out_t o;
    o.cyc = c; o.pc = pc; o.instr = instr;
    out_q.push_back(o);
  endtask

  task automatic probe(input int c, input int k, input logic [31:0] v);
    probe_t p;
    p.cyc = c; p.kind = k; p.exp = v;
    probe_q.push_back(p);
  endtask

  // Asserts reset mid-cycle and probes the reset values in that same cycle.
  task automatic go_reset();
    int c;
    c = cyc_cnt;
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    man_rv = 1'b0; man_rd = '0;
    probe(c, P_EMPTY, 32'h0);
    probe(c, P_VALID, 32'h0);
    probe(c, P_PC,    32'h0);
    probe(c, P_INSTR, 32'h0);
    probe(c, P_OPC,   32'h0);
    probe(c, P_REQ,   32'h0);
    probe(c, P_ADDR,  32'h0);
    wait_cyc(c + 2);
  endtask

  task automatic do_release(output int r);
    rst_n = 1'b1;
    r = cyc_cnt;
  endtask

  initial begin
    int r, r2;
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    man_rv = 1'b0; man_rd = '0; auto_mem = 1'b1; mem_lat = 1;
    wait_cyc(1);
    go_reset();

    // Streaming with latency 1: a request every two cycles
    do_release(r);
    exp_req(32'h0, r + 1);
    exp_out(32'h0, 32'hC300_0000, r + 3);
    exp_req(32'h4, r + 3);
    exp_out(32'h4, 32'hC700_0004, r + 5);
    exp_req(32'h8, r + 5);
    exp_out(32'h8, 32'hCB00_0008, r + 7);
    exp_req(32'hC, r + 7);
    wait_cyc(r + 8);
    go_reset();

    // Stall while the next word returns: hold buffer, then release
    do_release(r);
    exp_req(32'h0, r + 1);
    exp_out(32'h0, 32'hC300_0000, r + 3);
    exp_req(32'h4, r + 3);
    exp_req(32'h8, r + 5);
    exp_out(32'h4, 32'hC700_0004, r + 10);
    exp_out(32'h8, 32'hCB00_0008, r + 11);
    exp_req(32'hC, r + 11);
    probe(r + 6, P_VALID, 32'h1);
    probe(r + 6, P_PC,    32'h4);
    probe(r + 8, P_VALID, 32'h1);
    probe(r + 8, P_PC,    32'h4);
    probe(r + 8, P_INSTR, 32'hC700_0004);
    probe(r + 8, P_REQ,   32'h0);
    wait_cyc(r + 5); stall = 1'b1;
    wait_cyc(r + 10); stall = 1'b0;
    wait_cyc(r + 12);
    go_reset();

    // Redirect while waiting: late word is killed, fetch restarts aligned
    auto_mem = 1'b0;
    do_release(r);
    exp_req(32'h0, r + 1);
    exp_req(32'h100, r + 5);
    exp_out(32'h100, 32'hC300_0100, r + 7);
    exp_req(32'h104, r + 7);
    probe(r + 3, P_VALID, 32'h0);
    probe(r + 4, P_VALID, 32'h0);
    probe(r + 5, P_VALID, 32'h0);
    probe(r + 6, P_VALID, 32'h0);
    wait_cyc(r + 2); branch_taken = 1'b1; branch_target = 32'h103;
    wait_cyc(r + 3); branch_taken = 1'b0;
    wait_cyc(r + 4); man_rv = 1'b1; man_rd = 32'hDEAD_BEEF;
    wait_cyc(r + 5); man_rv = 1'b0;
    wait_cyc(r + 6); man_rv = 1'b1; man_rd = 32'hC300_0100;
    wait_cyc(r + 7); man_rv = 1'b0;
    wait_cyc(r + 8);
    go_reset();

    // Redirect coinciding with rvalid; redirect flushing a stalled slot
    do_release(r);
    exp_req(32'h0, r + 1);
    exp_req(32'h40, r + 3);
    exp_req(32'h44, r + 5);
    exp_req(32'h200, r + 8);
    probe(r + 3, P_VALID, 32'h0);
    probe(r + 4, P_VALID, 32'h0);
    probe(r + 5, P_VALID, 32'h1);
    probe(r + 5, P_PC,    32'h40);
    probe(r + 5, P_INSTR, 32'hAB00_0040);
    probe(r + 5, P_OPC,   32'hAB);
    probe(r + 6, P_VALID, 32'h1);
    probe(r + 7, P_VALID, 32'h0);
    probe(r + 8, P_VALID, 32'h0);
    wait_cyc(r + 2); man_rv = 1'b1; man_rd = 32'h1111_1111;
                     branch_taken = 1'b1; branch_target = 32'h40;
    wait_cyc(r + 3); man_rv = 1'b0; branch_taken = 1'b0;
    wait_cyc(r + 4); man_rv = 1'b1; man_rd = 32'hAB00_0040;
    wait_cyc(r + 5); man_rv = 1'b0; stall = 1'b1;
    wait_cyc(r + 6); branch_taken = 1'b1; branch_target = 32'h200;
    wait_cyc(r + 7); branch_taken = 1'b0; stall = 1'b0;
                     man_rv = 1'b1; man_rd = 32'h5555_5555;
    wait_cyc(r + 8); man_rv = 1'b0;
    wait_cyc(r + 9);
    go_reset();

    // PC wrap at the top of the address space, memory latency 2
    auto_mem = 1'b1; mem_lat = 2;
    do_release(r);
    exp_req(32'h0, r + 1);
    exp_req(32'hFFFF_FFFC, r + 4);
    exp_out(32'hFFFF_FFFC, 32'h3F00_FFFC, r + 7);
    exp_req(32'h0, r + 7);
    wait_cyc(r + 2); branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    wait_cyc(r + 3); branch_taken = 1'b0;
    wait_cyc(r + 8);
    go_reset();

    // Reset during WAIT; the stale response arrives after release
    auto_mem = 1'b0; mem_lat = 1;
    do_release(r);
    exp_req(32'h0, r + 1);
    wait_cyc(r + 3);
    go_reset();
    man_rv = 1'b1; man_rd = 32'hBADB_AD00;
    do_release(r2);
    exp_req(32'h0, r2 + 1);
    exp_out(32'h0, 32'h1234_5678, r2 + 4);
    exp_req(32'h4, r2 + 4);
    probe(r2 + 1, P_VALID, 32'h0);
    probe(r2 + 2, P_VALID, 32'h0);
    probe(r2 + 3, P_VALID, 32'h0);
    wait_cyc(r2 + 2); man_rv = 1'b0;
    wait_cyc(r2 + 3); man_rv = 1'b1; man_rd = 32'h1234_5678;
    wait_cyc(r2 + 4); man_rv = 1'b0;
    wait_cyc(r2 + 5);
    go_reset();

    wait_cyc(cyc_cnt + 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
